mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Memory-stage load/store controller for the MIPS pipeline. It accepts one load or store per transaction from the EX/MEM boundary and drives a word-aligned request/grant/response memory port, generating byte strobes for sub-word and unaligned stores. It merges or extends returned load data (lb/lbu/lh/lhu/lw/lwl/lwr) into the writeback value. It stalls the pipeline through `req_ready` and flags address errors and memory timeouts.

## Interface
- `TIMEOUT_CYCLES`, 255: max cycles spent in REQ+WAIT before aborting; 0 disables timeout.
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous active-low reset.
- `req_valid` in 1: pipeline presents a memory op.
- `req_ready` out 1: controller can accept; high only in IDLE.
- `req_op` in 6: MIPS opcode field.
- `req_addr` in 32: effective byte address.
- `req_rt` in 32: rt value; store data and lwl/lwr merge source.
- `req_dest` in 5: destination register for loads.
- `mem_req` out 1: memory request, held until granted.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: `{addr[31:2],2'b00}`.
- `mem_wstrb` out 4: byte lane enables, lane 0 = bits 7:0.
- `mem_wdata` out 32: lane-aligned store data.
- `mem_gnt` in 1: request accepted this cycle.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in 32: read word.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_we` out 1: register write enable, qualified by resp_valid.
- `resp_data` out 32: writeback value.
- `resp_dest` out 5: captured req_dest.
- `err_adel` / `err_ades` / `err_timeout` out 1 each: error pulses coincident with resp_valid.

## Operation
- Opcodes: loads lb 100000, lh 100001, lwl 100010, lw 100011, lbu 100100, lhu 100101, lwr 100110. Stores sb 101000, sh 101001, swl 101010, sw 101011, swr 101110. Any other opcode is a no-op: no memory access, completes with resp_we=0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE: on req_valid, capture op/addr/rt/dest. Let `k = addr[1:0]`.
  - Misaligned (lh/lhu/sh with k[0]=1; lw/sw with k≠0) -> DONE with err_adel (loads) or err_ades (stores). No memory access.
  - No-op opcode -> DONE.
  - Otherwise -> REQ.
- REQ: mem_req=1 with address, we, strobe and data held stable. On mem_gnt: store -> DONE (posted write); load -> WAIT. mem_rvalid in REQ is ignored.
- WAIT: on mem_rvalid, register the merged result -> DONE.
- DONE: resp_valid=1 for one cycle -> IDLE. resp_we=1 only for a load completing without error.
- Store strobes and data (little-endian):
  - sb: strobe `1<<k`, data `{4{rt[7:0]}}`.
  - sh: strobe `0011<<k`, data `{2{rt[15:0]}}`.
  - sw: strobe 1111, data rt.
  - swl: strobe `(1<<(k+1))-1`, data `rt>>(8*(3-k))`.
  - swr: strobe `1111<<k`, data `rt<<(8*k)`.
- Load results (r = rdata):
  - lb/lbu: byte k, sign- or zero-extended.
  - lh/lhu: halfword k[1], sign- or zero-extended.
  - lw: r.
  - lwl: k=0 `{r[7:0],rt[23:0]}`; 1 `{r[15:0],rt[15:0]}`; 2 `{r[23:0],rt[7:0]}`; 3 r.
  - lwr: k=0 r; 1 `{rt[31:24],r[31:8]}`; 2 `{rt[31:16],r[31:16]}`; 3 `{rt[31:8],r[31:24]}`.
- Timeout: 8-bit counter cleared on leaving IDLE, increments each cycle in REQ/WAIT. On reaching TIMEOUT_CYCLES: deassert mem_req -> DONE with err_timeout=1 and resp_we=0. A late mem_rvalid arriving in IDLE or DONE is ignored.

## Timing
- Reset (async, any state): state=IDLE, mem_req=0, resp_valid=0, all error outputs 0, resp_data/resp_dest/mem_* = 0, counter=0. req_ready=1 (decoded from IDLE).
- Reset mid-transaction abandons it with no response. Memory-side cleanup is the memory's responsibility.
- All outputs are registered or decoded from state only; there is no combinational path from mem_* inputs to outputs.
- Minimum latency, accept cycle to resp_valid: load 3 cycles (REQ with gnt, WAIT with rvalid, DONE); store 2 cycles; error or no-op 1 cycle.
- Back-to-back throughput: one transaction per (latency+1) cycles; req_ready rises the cycle after DONE.
- gnt and rvalid in the same cycle while in REQ: gnt is taken, rvalid is ignored, and the memory must re-present data.

## Test plan
- lw addr 0x100, gnt immediate, rdata 0x12345678 next cycle -> resp_valid on the 3rd cycle after accept, resp_data 0x12345678, resp_we=1, mem_addr 0x100.
- lb addr 0x203, rdata 0x80FFFFFF -> resp_data 0xFFFFFF80; lbu same -> 0x00000080.
- lwl addr 0x1, rt 0xAABBCCDD, rdata 0x11223344 -> 0x3344CCDD; lwr addr 0x2 same -> 0xAABB1122.
- sb addr 0x12, rt 0x000000EE -> mem_wstrb 0100, mem_wdata 0xEEEEEEEE, mem_we=1, resp_we=0. swl addr 0x1, rt 0xAABBCCDD -> strobe 0011, data 0x0000AABB.
- sh addr 0x3 -> no mem_req, err_ades=1 with resp_valid one cycle after accept. lw addr 0x2 -> err_adel.
- TIMEOUT_CYCLES=4, gnt never asserted -> err_timeout pulse and mem_req drops after 4 REQ cycles. Separately, resetn low during WAIT -> all outputs 0 immediately, req_ready=1, no resp_valid.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller: drives a word-aligned req/gnt/rvalid port,
// builds store strobes/data and merges or extends load data for writeback.
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [5:0]  req_op_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_rt_i,
   input  logic [4:0]  req_dest_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_wstrb_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        resp_valid_o,
   output logic        resp_we_o,
   output logic [31:0] resp_data_o,
   output logic [4:0]  resp_dest_o,
   output logic        err_adel_o,
   output logic        err_ades_o,
   output logic        err_timeout_o
);

   localparam logic [5:0] OpLb  = 6'b100000;
   localparam logic [5:0] OpLh  = 6'b100001;
   localparam logic [5:0] OpLwl = 6'b100010;
   localparam logic [5:0] OpLw  = 6'b100011;
   localparam logic [5:0] OpLbu = 6'b100100;
   localparam logic [5:0] OpLhu = 6'b100101;
   localparam logic [5:0] OpLwr = 6'b100110;
   localparam logic [5:0] OpSb  = 6'b101000;
   localparam logic [5:0] OpSh  = 6'b101001;
   localparam logic [5:0] OpSwl = 6'b101010;
   localparam logic [5:0] OpSw  = 6'b101011;
   localparam logic [5:0] OpSwr = 6'b101110;

   localparam logic [8:0] TimeoutLim = 9'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

   state_e      state_q, state_d;
   logic [5:0]  op_q, op_d;
   logic [1:0]  k_q, k_d;
   logic [31:0] rt_q, rt_d;
   logic [4:0]  dest_q, dest_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [3:0]  mem_wstrb_q, mem_wstrb_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] resp_data_q, resp_data_d;
   logic        resp_we_q, resp_we_d;
   logic        err_adel_q, err_adel_d;
   logic        err_ades_q, err_ades_d;
   logic        err_to_q, err_to_d;

   logic        in_load, in_store, in_misalign;
   logic [1:0]  in_k;
   logic [3:0]  st_strb;
   logic [31:0] st_data;
   logic [31:0] ld_data;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [8:0]  cnt_inc;
   logic        timeout_hit;

   assign in_k = req_addr_i[1:0];

   // Classify the incoming opcode and detect alignment faults.
   always_comb begin
      in_load     = 1'b0;
      in_store    = 1'b0;
      in_misalign = 1'b0;
      unique case (req_op_i)
         OpLb, OpLbu, OpLwl, OpLwr: in_load = 1'b1;
         OpLh, OpLhu: begin
            in_load     = 1'b1;
            in_misalign = in_k[0];
         end
         OpLw: begin
            in_load     = 1'b1;
            in_misalign = (in_k != 2'd0);
         end
         OpSb, OpSwl, OpSwr: in_store = 1'b1;
         OpSh: begin
            in_store    = 1'b1;
            in_misalign = in_k[0];
         end
         OpSw: begin
            in_store    = 1'b1;
            in_misalign = (in_k != 2'd0);
         end
         default: ;
      endcase
   end

   // Lane-aligned store strobe and data, little-endian.
   always_comb begin
      st_strb = 4'b0000;
      st_data = 32'h0;
      unique case (req_op_i)
         OpSb: begin
            st_strb = 4'b0001 << in_k;
            st_data = {4{req_rt_i[7:0]}};
         end
         OpSh: begin
            st_strb = 4'b0011 << in_k;
            st_data = {2{req_rt_i[15:0]}};
         end
         OpSw: begin
            st_strb = 4'b1111;
            st_data = req_rt_i;
         end
         OpSwl: begin
            unique case (in_k)
               2'd0: begin st_strb = 4'b0001; st_data = {24'h0, req_rt_i[31:24]}; end
               2'd1: begin st_strb = 4'b0011; st_data = {16'h0, req_rt_i[31:16]}; end
               2'd2: begin st_strb = 4'b0111; st_data = {8'h0, req_rt_i[31:8]}; end
               default: begin st_strb = 4'b1111; st_data = req_rt_i; end
            endcase
         end
         OpSwr: begin
            unique case (in_k)
               2'd0: begin st_strb = 4'b1111; st_data = req_rt_i; end
               2'd1: begin st_strb = 4'b1110; st_data = {req_rt_i[23:0], 8'h0}; end
               2'd2: begin st_strb = 4'b1100; st_data = {req_rt_i[15:0], 16'h0}; end
               default: begin st_strb = 4'b1000; st_data = {req_rt_i[7:0], 24'h0}; end
            endcase
         end
         default: ;
      endcase
   end

   // Extend or merge returned read data for the captured load.
   always_comb begin
      unique case (k_q)
         2'd0: ld_byte = mem_rdata_i[7:0];
         2'd1: ld_byte = mem_rdata_i[15:8];
         2'd2: ld_byte = mem_rdata_i[23:16];
         default: ld_byte = mem_rdata_i[31:24];
      endcase
      ld_half = k_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
      ld_data = mem_rdata_i;
      unique case (op_q)
         OpLb:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         OpLbu: ld_data = {24'h0, ld_byte};
         OpLh:  ld_data = {{16{ld_half[15]}}, ld_half};
         OpLhu: ld_data = {16'h0, ld_half};
         OpLwl: begin
            unique case (k_q)
               2'd0: ld_data = {mem_rdata_i[7:0], rt_q[23:0]};
               2'd1: ld_data = {mem_rdata_i[15:0], rt_q[15:0]};
               2'd2: ld_data = {mem_rdata_i[23:0], rt_q[7:0]};
               default: ld_data = mem_rdata_i;
            endcase
         end
         OpLwr: begin
            unique case (k_q)
               2'd0: ld_data = mem_rdata_i;
               2'd1: ld_data = {rt_q[31:24], mem_rdata_i[31:8]};
               2'd2: ld_data = {rt_q[31:16], mem_rdata_i[31:16]};
               default: ld_data = {rt_q[31:8], mem_rdata_i[31:24]};
            endcase
         end
         default: ld_data = mem_rdata_i;
      endcase
   end

   assign cnt_inc     = {1'b0, cnt_q} + 9'd1;
   assign timeout_hit = (TimeoutLim != 9'd0) && (cnt_inc == TimeoutLim);

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      k_d         = k_q;
      rt_d        = rt_q;
      dest_d      = dest_q;
      cnt_d       = cnt_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wstrb_d = mem_wstrb_q;
      mem_wdata_d = mem_wdata_q;
      resp_data_d = resp_data_q;
      resp_we_d   = resp_we_q;
      err_adel_d  = err_adel_q;
      err_ades_d  = err_ades_q;
      err_to_d    = err_to_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid_i) begin
               op_d        = req_op_i;
               k_d         = in_k;
               rt_d        = req_rt_i;
               dest_d      = req_dest_i;
               cnt_d       = 8'd0;
               mem_we_d    = in_store;
               mem_addr_d  = {req_addr_i[31:2], 2'b00};
               mem_wstrb_d = st_strb;
               mem_wdata_d = st_data;
               resp_data_d = 32'h0;
               resp_we_d   = 1'b0;
               err_adel_d  = in_load & in_misalign;
               err_ades_d  = in_store & in_misalign;
               err_to_d    = 1'b0;
               if (in_misalign || !(in_load || in_store)) state_d = StDone;
               else                                       state_d = StReq;
            end
         end
         StReq: begin
            cnt_d = cnt_inc[7:0];
            if (mem_gnt_i) begin
               state_d = mem_we_q ? StDone : StWait;
            end else if (timeout_hit) begin
               err_to_d = 1'b1;
               state_d  = StDone;
            end
         end
         StWait: begin
            cnt_d = cnt_inc[7:0];
            if (mem_rvalid_i) begin
               resp_data_d = ld_data;
               resp_we_d   = 1'b1;
               state_d     = StDone;
            end else if (timeout_hit) begin
               err_to_d = 1'b1;
               state_d  = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         op_q        <= 6'h0;
         k_q         <= 2'd0;
         rt_q        <= 32'h0;
         dest_q      <= 5'd0;
         cnt_q       <= 8'd0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_wstrb_q <= 4'h0;
         mem_wdata_q <= 32'h0;
         resp_data_q <= 32'h0;
         resp_we_q   <= 1'b0;
         err_adel_q  <= 1'b0;
         err_ades_q  <= 1'b0;
         err_to_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         k_q         <= k_d;
         rt_q        <= rt_d;
         dest_q      <= dest_d;
         cnt_q       <= cnt_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wstrb_q <= mem_wstrb_d;
         mem_wdata_q <= mem_wdata_d;
         resp_data_q <= resp_data_d;
         resp_we_q   <= resp_we_d;
         err_adel_q  <= err_adel_d;
         err_ades_q  <= err_ades_d;
         err_to_q    <= err_to_d;
      end
   end

   assign req_ready_o   = (state_q == StIdle);
   assign mem_req_o     = (state_q == StReq);
   assign mem_we_o      = mem_we_q;
   assign mem_addr_o    = mem_addr_q;
   assign mem_wstrb_o   = mem_wstrb_q;
   assign mem_wdata_o   = mem_wdata_q;
   assign resp_valid_o  = (state_q == StDone);
   assign resp_we_o     = resp_valid_o & resp_we_q;
   assign resp_data_o   = resp_data_q;
   assign resp_dest_o   = dest_q;
   assign err_adel_o    = resp_valid_o & err_adel_q;
   assign err_ades_o    = resp_valid_o & err_ades_q;
   assign err_timeout_o = resp_valid_o & err_to_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: loads, stores, address errors, timeout and
// mid-transaction reset, all against hand-computed expectations.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [5:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_rt;
   logic [4:0]  req_dest;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        resp_valid;
   logic        resp_we;
   logic [31:0] resp_data;
   logic [4:0]  resp_dest;
   logic        err_adel;
   logic        err_ades;
   logic        err_timeout;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready),
      .req_op_i      (req_op),
      .req_addr_i    (req_addr),
      .req_rt_i      (req_rt),
      .req_dest_i    (req_dest),
      .mem_req_o     (mem_req),
      .mem_we_o      (mem_we),
      .mem_addr_o    (mem_addr),
      .mem_wstrb_o   (mem_wstrb),
      .mem_wdata_o   (mem_wdata),
      .mem_gnt_i     (mem_gnt),
      .mem_rvalid_i  (mem_rvalid),
      .mem_rdata_i   (mem_rdata),
      .resp_valid_o  (resp_valid),
      .resp_we_o     (resp_we),
      .resp_data_o   (resp_data),
      .resp_dest_o   (resp_dest),
      .err_adel_o    (err_adel),
      .err_ades_o    (err_ades),
      .err_timeout_o (err_timeout)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Present one request for a single accept edge.
   task automatic start_op(input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] rt, input logic [4:0] dest);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_rt    = rt;
      req_dest  = dest;
      cyc();
      req_valid = 1'b0;
   endtask

   task automatic do_load(input string tag, input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] rt, input logic [31:0] rdata,
                          input logic [31:0] exp_data);
      start_op(op, addr, rt, 5'd9);
      check_eq({tag, ".req"}, {31'b0, mem_req}, 32'd1);
      check_eq({tag, ".addr"}, mem_addr, {addr[31:2], 2'b00});
      check_eq({tag, ".we"}, {31'b0, mem_we}, 32'd0);
      mem_gnt = 1'b1;
      cyc();
      mem_gnt = 1'b0;
      check_eq({tag, ".req_wait"}, {31'b0, mem_req}, 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      cyc();
      mem_rvalid = 1'b0;
      check_eq({tag, ".rvalid"}, {31'b0, resp_valid}, 32'd1);
      check_eq({tag, ".data"}, resp_data, exp_data);
      check_eq({tag, ".rwe"}, {31'b0, resp_we}, 32'd1);
      check_eq({tag, ".dest"}, {27'b0, resp_dest}, 32'd9);
      cyc();
      check_eq({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
   endtask

   task automatic do_store(input string tag, input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] rt, input logic [3:0] exp_strb,
                           input logic [31:0] exp_data);
      start_op(op, addr, rt, 5'd3);
      check_eq({tag, ".req"}, {31'b0, mem_req}, 32'd1);
      check_eq({tag, ".we"}, {31'b0, mem_we}, 32'd1);
      check_eq({tag, ".addr"}, mem_addr, {addr[31:2], 2'b00});
      check_eq({tag, ".strb"}, {28'b0, mem_wstrb}, {28'b0, exp_strb});
      check_eq({tag, ".wdata"}, mem_wdata, exp_data);
      mem_gnt = 1'b1;
      cyc();
      mem_gnt = 1'b0;
      check_eq({tag, ".rvalid"}, {31'b0, resp_valid}, 32'd1);
      check_eq({tag, ".rwe"}, {31'b0, resp_we}, 32'd0);
      cyc();
   endtask

   initial begin
      rst_n      = 1'b1;
      req_valid  = 1'b0;
      req_op     = 6'h0;
      req_addr   = 32'h0;
      req_rt     = 32'h0;
      req_dest   = 5'd0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      #1 rst_n = 1'b0;
      #2;
      check_eq("rst.ready", {31'b0, req_ready}, 32'd1);
      check_eq("rst.req", {31'b0, mem_req}, 32'd0);
      check_eq("rst.rvalid", {31'b0, resp_valid}, 32'd0);
      check_eq("rst.addr", mem_addr, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      do_load("lw", 6'b100011, 32'h100, 32'h0, 32'h12345678, 32'h12345678);
      do_load("lb", 6'b100000, 32'h203, 32'h0, 32'h80FFFFFF, 32'hFFFFFF80);
      do_load("lbu", 6'b100100, 32'h203, 32'h0, 32'h80FFFFFF, 32'h00000080);
      do_load("lh", 6'b100001, 32'h302, 32'h0, 32'h9ABC1234, 32'hFFFF9ABC);
      do_load("lhu", 6'b100101, 32'h300, 32'h0, 32'h9ABC8234, 32'h00008234);
      do_load("lwl", 6'b100010, 32'h1, 32'hAABBCCDD, 32'h11223344, 32'h3344CCDD);
      do_load("lwr", 6'b100110, 32'h2, 32'hAABBCCDD, 32'h11223344, 32'hAABB1122);
      do_load("lwr3", 6'b100110, 32'h3, 32'hAABBCCDD, 32'h11223344, 32'hAABBCC11);

      do_store("sb", 6'b101000, 32'h12, 32'h000000EE, 4'b0100, 32'hEEEEEEEE);
      do_store("sh", 6'b101001, 32'h22, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF);
      do_store("sw", 6'b101011, 32'h40, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);
      do_store("swl", 6'b101010, 32'h1, 32'hAABBCCDD, 4'b0011, 32'h0000AABB);
      do_store("swr", 6'b101110, 32'h1, 32'hAABBCCDD, 4'b1110, 32'hBBCCDD00);

      // Misaligned store and load complete one cycle after accept with no access.
      start_op(6'b101001, 32'h3, 32'h0, 5'd1);
      check_eq("ades.req", {31'b0, mem_req}, 32'd0);
      check_eq("ades.rvalid", {31'b0, resp_valid}, 32'd1);
      check_eq("ades.err", {31'b0, err_ades}, 32'd1);
      check_eq("ades.adel", {31'b0, err_adel}, 32'd0);
      cyc();
      check_eq("ades.pulse", {31'b0, resp_valid}, 32'd0);
      start_op(6'b100011, 32'h2, 32'h0, 5'd1);
      check_eq("adel.err", {31'b0, err_adel}, 32'd1);
      check_eq("adel.rwe", {31'b0, resp_we}, 32'd0);
      cyc();

      start_op(6'b000000, 32'h0, 32'h0, 5'd2);
      check_eq("nop.rvalid", {31'b0, resp_valid}, 32'd1);
      check_eq("nop.rwe", {31'b0, resp_we}, 32'd0);
      check_eq("nop.req", {31'b0, mem_req}, 32'd0);
      cyc();

      // Grant never arrives: four REQ cycles, then a timeout completion.
      start_op(6'b100011, 32'h40, 32'h0, 5'd4);
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("to.req%0d", i), {31'b0, mem_req}, 32'd1);
         cyc();
      end
      check_eq("to.req_drop", {31'b0, mem_req}, 32'd0);
      check_eq("to.rvalid", {31'b0, resp_valid}, 32'd1);
      check_eq("to.err", {31'b0, err_timeout}, 32'd1);
      check_eq("to.rwe", {31'b0, resp_we}, 32'd0);
      cyc();

      // Reset while waiting for read data abandons the load.
      start_op(6'b100011, 32'h80, 32'h0, 5'd7);
      mem_gnt = 1'b1;
      cyc();
      mem_gnt = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_eq("rstw.ready", {31'b0, req_ready}, 32'd1);
      check_eq("rstw.req", {31'b0, mem_req}, 32'd0);
      check_eq("rstw.addr", mem_addr, 32'h0);
      check_eq("rstw.dest", {27'b0, resp_dest}, 32'd0);
      check_eq("rstw.rvalid", {31'b0, resp_valid}, 32'd0);
      cyc();
      rst_n      = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEADBEEF;
      cyc();
      mem_rvalid = 1'b0;
      check_eq("rstw.late", {31'b0, resp_valid}, 32'd0);
      cyc();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
